ififo_feeder: RTL and testbench
===============================

// Module: ififo_feeder
// PURPOSE
//  Read-side controller for the weight input FIFO. Pops a programmed number of rows
//  (col*bw bits each) and presents them to the 2D PE array with a diagonal skew:
//  column c receives its nibble c cycles after column 0.
//  Sits between the FIFO read port (out/rd/o_empty) and the array's north weight inputs.
//  Runs a start/busy/done transaction with the top-level control FSM.
// PARAMETERS
//  col    8  number of array columns (FIFO word = col*bw)
//  bw     4  bitwidth of one weight
//  cnt_w  5  width of the row-count request; max rows = 2**cnt_w-1
// PORTS
//  clk         in   1          clock, rising edge
//  reset       in   1          asynchronous, active-LOW; 0 clears all state immediately
//  start       in   1          request a load of num_rows rows; sampled only in IDLE
//  num_rows    in   cnt_w      rows to transfer; sampled together with start
//  stall       in   1          array back-pressure: 1 freezes the feeder for that cycle
//  fifo_empty  in   1          FIFO o_empty
//  fifo_data   in   col*bw     FIFO out; combinational view of the head word
//  fifo_rd     out  1          FIFO rd (pop); combinational
//  w_out       out  col*bw     skewed weights; column c = w_out[c*bw +: bw]
//  w_valid     out  col        per-column valid for w_out
//  busy        out  1          transaction in progress
//  done        out  1          one-cycle pulse: last row has left the last column
// BEHAVIOUR
//  Reset values: w_out=0, w_valid=0, busy=0, done=0, fifo_rd=0, state=IDLE, counters=0.
//  FSM:
//   - IDLE: start=1 latches num_rows.
//     - num_rows!=0 -> LOAD.
//     - num_rows==0 -> DONE.
//   - LOAD: fifo_rd = !fifo_empty & !stall.
//     - Each pop increments the issued count.
//     - The pop that reaches num_rows -> DRAIN.
//   - DRAIN: counts col non-stalled cycles, then -> DONE.
//   - DONE: done=1 for exactly one cycle, then -> IDLE.
//  busy=1 in LOAD, DRAIN and DONE; 0 in IDLE.
//  start is ignored when not in IDLE; no queuing.
//  fifo_rd is never asserted outside LOAD, when fifo_empty=1, or when stall=1.
//  Skew pipeline:
//   - Column c holds a (c+1)-deep register chain of {valid, bw data}.
//   - On a pop, stage 0 of column c loads fifo_data[c*bw +: bw] with valid=1.
//   - In a non-popping, non-stalled cycle, stage 0 loads valid=0 (a bubble).
//   - w_out/w_valid column c = last stage of chain c.
//   - Latency: a pop in cycle T appears on column c in cycle T+1+c when no stall intervenes.
//  Empty FIFO in LOAD: inserts a bubble; the issued count does not advance; the bubble
//  propagates diagonally; row order is preserved.
//  Stall: all chains, counters and state hold; outputs keep their values; fifo_rd=0.
//   Each stalled cycle delays every later event by one cycle.
//  Invalid slots drive data 0. A stage flagged valid=0 never drives nonzero w_out.
//  Counters are cnt_w bits and saturate at num_rows; no wrap-around.
//  Reset mid-transaction: async clear; every in-flight row is discarded; the FIFO is not
//  rewound.
// TESTING
//  (col=8, bw=4; start sampled at the end of cycle 0)
//  1. FIFO holds A,B,C; num_rows=3; no stall.
//     -> fifo_rd=1 in cycles 1-3.
//     -> col0 valid in cycles 2-4 with A[3:0],B[3:0],C[3:0].
//     -> col7 valid in cycles 9-11 with A[31:28],B[31:28],C[31:28].
//     -> done=1 in cycle 12; busy=0 from cycle 13.
//  2. As 1, but fifo_empty=1 in cycle 2 only.
//     -> fifo_rd=0 in cycle 2; col0 valid gap in cycle 3; col7 gap in cycle 10.
//     -> all 3 rows delivered in order; done in cycle 13.
//  3. As 1, with stall=1 in cycles 5-6.
//     -> all w_out/w_valid hold in cycles 6-7; no pops during the stall.
//     -> done in cycle 14.
//  4. num_rows=0, start in cycle 0.
//     -> done in cycle 1; fifo_rd never 1; w_valid stays 0.
//  5. start=1 again in cycle 4 of scenario 1 -> ignored; exactly 3 pops; a single done pulse.
//  6. reset=0 asynchronously mid-cycle 6 of scenario 1.
//     -> w_valid=0, busy=0 and fifo_rd=0 immediately.
//     -> no done pulse.
//     -> a new start after release runs normally.

Source files
------------

// File: rtl/ififo_feeder.sv
// ififo_feeder: read-side controller for the weight input FIFO.
// Pops a programmed number of rows (col*bw bits each) and presents them to the
// PE array's north weight inputs with a diagonal skew. Column c sees its nibble
// c cycles after column 0. The block runs a start/busy/done handshake with the
// top-level control FSM.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous, active-low clear of all state
//   start       load request, sampled only in IDLE together with num_rows
//   num_rows    number of rows to transfer (0 completes immediately)
//   stall       array back-pressure; freezes FSM, counters and skew chains
//   fifo_empty  FIFO empty flag
//   fifo_data   FIFO head word (combinational view)
//   fifo_rd     FIFO pop strobe (combinational)
//   w_out       skewed weights, column c = w_out[c*bw +: bw]
//   w_valid     per-column valid for w_out
//   busy        high while a transaction is in progress
//   done        one-cycle completion pulse once the last row leaves the last column
module ififo_feeder #(
  parameter int col   = 8,
  parameter int bw    = 4,
  parameter int cnt_w = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [cnt_w-1:0]    num_rows,
  input  logic                stall,
  input  logic                fifo_empty,
  input  logic [col*bw-1:0]   fifo_data,
  output logic                fifo_rd,
  output logic [col*bw-1:0]   w_out,
  output logic [col-1:0]      w_valid,
  output logic                busy,
  output logic                done
);

  localparam int DW = $clog2(col + 1);
  // One skew-chain entry: {valid, data}.
  localparam int E  = bw + 1;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_e;

  state_e           state_q, state_d;
  logic [cnt_w-1:0] rows_q, rows_d;
  logic [cnt_w-1:0] issued_q, issued_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic             pop;

  always_comb begin
    state_d  = state_q;
    rows_d   = rows_q;
    issued_d = issued_q;
    drain_d  = drain_q;
    pop      = 1'b0;
    if (!stall) begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            rows_d   = num_rows;
            issued_d = '0;
            drain_d  = '0;
            state_d  = (num_rows != '0) ? LOAD : DONE;
          end
        end
        LOAD: begin
          if (!fifo_empty) begin
            pop = 1'b1;
            if (issued_q != rows_q) issued_d = issued_q + 1'b1;
            if (issued_d == rows_q) state_d = DRAIN;
          end
        end
        DRAIN: begin
          // col cycles let the last row walk down the deepest chain.
          if (drain_q == DW'(col - 1)) state_d = DONE;
          else                         drain_d = drain_q + 1'b1;
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      rows_q   <= '0;
      issued_q <= '0;
      drain_q  <= '0;
    end else begin
      state_q  <= state_d;
      rows_q   <= rows_d;
      issued_q <= issued_d;
      drain_q  <= drain_d;
    end
  end

  assign fifo_rd = pop;
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);

  // Column c: (c+1)-deep chain packed as entries, entry 0 in the low bits.
  for (genvar c = 0; c < col; c++) begin : g_col
    logic [(c+1)*E-1:0] chain_q, chain_d, shifted;
    logic [E-1:0]       new_e;

    // Bubbles carry zero data so an invalid slot never shows nonzero weights.
    assign new_e = {pop, fifo_data[c*bw +: bw] & {bw{pop}}};

    if (c == 0) begin : g_first
      assign shifted = new_e;
    end else begin : g_rest
      assign shifted = {chain_q[c*E-1:0], new_e};
    end

    always_comb begin
      chain_d = chain_q;
      if (!stall) chain_d = shifted;
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) chain_q <= '0;
      else        chain_q <= chain_d;
    end

    assign w_out[c*bw +: bw] = chain_q[c*E +: bw];
    assign w_valid[c]        = chain_q[(c+1)*E-1];
  end

endmodule

// File: tb/tb_ififo_feeder.sv
module tb_ififo_feeder;
  localparam int COL = 8;
  localparam int BW  = 4;
  localparam int CW  = 5;
  localparam int W   = COL * BW;

  localparam logic [W-1:0] A = 32'h9ABCDEF1;
  localparam logic [W-1:0] B = 32'h2468ACE3;
  localparam logic [W-1:0] C = 32'h13579BDF;
  localparam logic [W-1:0] D = 32'h76543212;
  localparam logic [W-1:0] E = 32'h0FEDCBA7;
  localparam logic [W-1:0] F = 32'h11111116;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] num_rows = '0;
  logic          stall = 1'b0;
  logic          force_empty = 1'b0;
  logic          fifo_empty;
  logic [W-1:0]  fifo_data;
  logic          fifo_rd;
  logic [W-1:0]  w_out;
  logic [COL-1:0] w_valid;
  logic          busy;
  logic          done;

  // Simple FIFO environment: never rewound, popped by the DUT's fifo_rd.
  logic [W-1:0] fmem [64];
  int fwr = 0;
  int frd = 0;
  assign fifo_empty = (frd == fwr) || force_empty;
  assign fifo_data  = (frd != fwr) ? fmem[frd % 64] : '0;

  ififo_feeder #(.col(COL), .bw(BW), .cnt_w(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .num_rows(num_rows), .stall(stall),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_rd(fifo_rd),
    .w_out(w_out), .w_valid(w_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Transaction-level model: a history of what entered the array on each
  // advancing (non-stalled) cycle; column c shows the entry c+1 advances back.
  int   cyc = 0;
  int   adv = 0;
  bit   hv [512];
  logic [W-1:0] hd [512];
  bit   m_active = 0;
  int   m_rows = 0;
  int   m_drain = 0;
  bit   m_rd;
  int   done_cnt = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      adv = 0; m_active = 0; m_rows = 0; m_drain = 0;
    end else begin
      if (!stall) begin
        m_rd = m_active && (m_rows > 0) && !fifo_empty;
        hv[adv] = m_rd;
        hd[adv] = m_rd ? fifo_data : '0;
        adv++;
        if (!m_active) begin
          if (start) begin
            m_active = 1;
            m_rows   = int'(num_rows);
            m_drain  = (num_rows == 0) ? 0 : COL;
          end
        end else if (m_rows > 0) begin
          if (m_rd) m_rows--;
        end else if (m_drain > 0) begin
          m_drain--;
        end else begin
          m_active = 0;
        end
      end
      if (fifo_rd) frd++;
      cyc++;
    end
  end

  logic           e_rd, e_done;
  logic [COL-1:0] e_v;
  logic [W-1:0]   e_o;
  int             idx;

  always @(negedge clk) begin
    if (reset) begin
      e_rd   = m_active && (m_rows > 0) && !fifo_empty && !stall;
      e_done = m_active && (m_rows == 0) && (m_drain == 0);
      e_v = '0;
      e_o = '0;
      for (int c = 0; c < COL; c++) begin
        idx = adv - 1 - c;
        if (idx >= 0 && hv[idx]) begin
          e_v[c] = 1'b1;
          e_o[c*BW +: BW] = hd[idx][c*BW +: BW];
        end
      end
      chk("busy", busy, m_active);
      chk("done", done, e_done);
      chk("fifo_rd", fifo_rd, e_rd);
      chk("w_valid", w_valid, e_v);
      chk("w_out", w_out, e_o);
      if (done) done_cnt++;
    end
  end

  int t0 = 0;

  task automatic goto(input int k);
    while (cyc < t0 + k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic at_neg(input int k);
    goto(k);
    @(negedge clk);
  endtask

  task automatic push(input logic [W-1:0] w);
    fmem[fwr % 64] = w;
    fwr++;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_rd", fifo_rd, 1'b0);
    chk("rst_wvalid", w_valid, '0);
    chk("rst_wout", w_out, '0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic begin_txn(input int n);
    t0 = cyc;
    start = 1'b1;
    num_rows = CW'(n);
    goto(1);
    start = 1'b0;
    num_rows = '0;
  endtask

  int frd0, d0;

  initial begin
    @(posedge clk); #1;

    // Scenario 1: three rows, no stall.
    apply_reset();
    push(A); push(B); push(C);
    begin_txn(3);
    at_neg(1);  chk("s1_rd_c1", fifo_rd, 1'b1);
    at_neg(2);  chk("s1_rd_c2", fifo_rd, 1'b1);
                chk("s1_c0v_c2", w_valid[0], 1'b1);
                chk("s1_c0d_c2", w_out[3:0], 4'h1);
    at_neg(3);  chk("s1_rd_c3", fifo_rd, 1'b1);
                chk("s1_c0d_c3", w_out[3:0], 4'h3);
    at_neg(4);  chk("s1_rd_c4", fifo_rd, 1'b0);
                chk("s1_c0d_c4", w_out[3:0], 4'hF);
    at_neg(8);  chk("s1_c7v_c8", w_valid[7], 1'b0);
    at_neg(9);  chk("s1_c7v_c9", w_valid[7], 1'b1);
                chk("s1_c7d_c9", w_out[31:28], 4'h9);
    at_neg(11); chk("s1_c7d_c11", w_out[31:28], 4'h1);
                chk("s1_done_c11", done, 1'b0);
    at_neg(12); chk("s1_done_c12", done, 1'b1);
    at_neg(13); chk("s1_busy_c13", busy, 1'b0);

    // Scenario 2: FIFO empty in cycle 2 only.
    apply_reset();
    push(A); push(B); push(C);
    begin_txn(3);
    goto(2); force_empty = 1'b1;
    at_neg(2);  chk("s2_rd_c2", fifo_rd, 1'b0);
    goto(3); force_empty = 1'b0;
    at_neg(3);  chk("s2_c0v_c3", w_valid[0], 1'b0);
    at_neg(4);  chk("s2_c0d_c4", w_out[3:0], 4'h3);
    at_neg(10); chk("s2_c7v_c10", w_valid[7], 1'b0);
    at_neg(12); chk("s2_c7d_c12", w_out[31:28], 4'h1);
                chk("s2_done_c12", done, 1'b0);
    at_neg(13); chk("s2_done_c13", done, 1'b1);

    // Scenario 3: stall in cycles 5-6.
    apply_reset();
    push(A); push(B); push(C);
    begin_txn(3);
    goto(5); stall = 1'b1;
    at_neg(5);  chk("s3_c1d_c5", w_out[7:4], 4'hD);
    at_neg(6);  chk("s3_c1d_c6", w_out[7:4], 4'hD);
                chk("s3_c1v_c6", w_valid[1], 1'b1);
    goto(7); stall = 1'b0;
    at_neg(7);  chk("s3_c1d_c7", w_out[7:4], 4'hD);
    at_neg(8);  chk("s3_c1v_c8", w_valid[1], 1'b0);
    at_neg(13); chk("s3_done_c13", done, 1'b0);
    at_neg(14); chk("s3_done_c14", done, 1'b1);

    // Scenario 4: zero rows.
    apply_reset();
    begin_txn(0);
    at_neg(1);  chk("s4_done_c1", done, 1'b1);
                chk("s4_rd_c1", fifo_rd, 1'b0);
    at_neg(2);  chk("s4_busy_c2", busy, 1'b0);
                chk("s4_done_c2", done, 1'b0);

    // Scenario 5: second start while busy is ignored.
    apply_reset();
    push(A); push(B); push(C); push(D);
    frd0 = frd;
    d0 = done_cnt;
    begin_txn(3);
    goto(4); start = 1'b1; num_rows = 5'd5;
    goto(5); start = 1'b0; num_rows = '0;
    at_neg(12); chk("s5_done_c12", done, 1'b1);
    goto(20);
    chk("s5_pops", frd - frd0, 3);
    chk("s5_done_pulses", done_cnt - d0, 1);

    // Scenario 6: asynchronous reset mid-transaction (FIFO head is D, then A, B).
    apply_reset();
    push(A); push(B); push(C);
    begin_txn(3);
    goto(6);
    #2 reset = 1'b0;
    #1;
    chk("s6_wvalid_rst", w_valid, '0);
    chk("s6_busy_rst", busy, 1'b0);
    chk("s6_rd_rst", fifo_rd, 1'b0);
    chk("s6_wout_rst", w_out, '0);
    d0 = done_cnt;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    chk("s6_no_done", done_cnt - d0, 0);
    push(E); push(F);
    begin_txn(2);
    at_neg(2);  chk("s6_c0d_c2", w_out[3:0], 4'hF);
    at_neg(3);  chk("s6_c0d_c3", w_out[3:0], 4'h7);
    at_neg(11); chk("s6_done_c11", done, 1'b1);
    goto(14);
    chk("s6_done_pulses", done_cnt - d0, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got %0d/%0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
